// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage state and occupancy types
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one payload register with load enable plus its valid flop
module pipe_slot #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              valid_d,
    output logic [DATA_W-1:0] data,
    output logic              valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= valid_d;
            if (wr_en) begin
                data <= wr_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic valid/ready pipeline register with optional skid entry
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output occ_t              occupancy
);

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_e       state, state_nxt;
            logic              ready_q;
            logic              accept, issue;
            logic              main_we, skid_we, main_vd, skid_vd;
            logic              main_valid, skid_valid;
            logic [DATA_W-1:0] main_wd, main_data, skid_data;

            assign accept = in_valid & ready_q;
            assign issue  = main_valid & out_ready;

            always_comb begin
                state_nxt = state;
                main_we   = 1'b0;
                skid_we   = 1'b0;
                main_wd   = in_data;
                case (state)
                    PS_EMPTY: begin
                        if (accept) begin
                            main_we   = 1'b1;
                            state_nxt = PS_ONE;
                        end
                    end
                    PS_ONE: begin
                        if (accept && issue) begin
                            main_we = 1'b1;
                        end else if (accept) begin
                            skid_we   = 1'b1;
                            state_nxt = PS_FULL;
                        end else if (issue) begin
                            state_nxt = PS_EMPTY;
                        end
                    end
                    PS_FULL: begin
                        if (issue) begin
                            main_we   = 1'b1;
                            main_wd   = skid_data;
                            state_nxt = PS_ONE;
                        end
                    end
                    default: state_nxt = PS_EMPTY;
                endcase
                // A payload handshaken during flush is dropped along with the held ones.
                if (flush) begin
                    state_nxt = PS_EMPTY;
                    main_we   = 1'b0;
                    skid_we   = 1'b0;
                end
            end

            assign main_vd = (state_nxt != PS_EMPTY);
            assign skid_vd = (state_nxt == PS_FULL);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state   <= PS_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    state   <= state_nxt;
                    ready_q <= (state_nxt != PS_FULL);
                end
            end

            pipe_slot #(.DATA_W(DATA_W)) u_main (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (main_we),
                .wr_data (main_wd),
                .valid_d (main_vd),
                .data    (main_data),
                .valid   (main_valid)
            );

            pipe_slot #(.DATA_W(DATA_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (skid_we),
                .wr_data (in_data),
                .valid_d (skid_vd),
                .data    (skid_data),
                .valid   (skid_valid)
            );

            assign in_ready  = ready_q;
            assign out_valid = main_valid;
            assign out_data  = main_data;
            assign occupancy = {skid_valid, main_valid & ~skid_valid};
        end else begin : g_reg
            logic              accept, issue, vd, valid;
            logic [DATA_W-1:0] data;

            assign in_ready = ~valid | out_ready;
            assign accept   = in_valid & in_ready;
            assign issue    = valid & out_ready;
            assign vd       = ~flush & (accept | (valid & ~issue));

            pipe_slot #(.DATA_W(DATA_W)) u_main (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (accept & ~flush),
                .wr_data (in_data),
                .valid_d (vd),
                .data    (data),
                .valid   (valid)
            );

            assign out_valid = valid;
            assign out_data  = data;
            assign occupancy = {1'b0, valid};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid in both modes and widths
module tb_pipe_stage_skid;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush     [N];
    logic         in_valid  [N];
    logic         in_ready  [N];
    logic         out_valid [N];
    logic         out_ready [N];
    logic [127:0] in_data   [N];
    logic [127:0] out_data  [N];
    logic [1:0]   occupancy [N];
    logic [127:0] od0, od1;
    logic         od2, od3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] m_data [N][2];
    int           m_cnt  [N];

    always #5 clk = ~clk;

    assign out_data[0] = od0;
    assign out_data[1] = od1;
    assign out_data[2] = {127'b0, od2};
    assign out_data[3] = {127'b0, od3};

    pipe_stage_skid #(.DATA_W(128), .SKID(1)) u_skid_w128 (
        .clk(clk), .rst(rst), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(od0), .occupancy(occupancy[0]));

    pipe_stage_skid #(.DATA_W(128), .SKID(0)) u_reg_w128 (
        .clk(clk), .rst(rst), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(od1), .occupancy(occupancy[1]));

    pipe_stage_skid #(.DATA_W(1), .SKID(1)) u_skid_w1 (
        .clk(clk), .rst(rst), .flush(flush[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2][0:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(od2), .occupancy(occupancy[2]));

    pipe_stage_skid #(.DATA_W(1), .SKID(0)) u_reg_w1 (
        .clk(clk), .rst(rst), .flush(flush[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data[3][0:0]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .out_data(od3), .occupancy(occupancy[3]));

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            flush[i]     = 1'b0;
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            in_data[i]   = '0;
        end
    endtask

    task automatic do_reset();
        idle_all();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < N; i++) begin
            n_checks += 4;
            if (out_valid[i] !== 1'b0) begin
                n_fail++; $display("FAIL reset_out_valid dut%0d got %0b want 0", i, out_valid[i]);
            end
            if (occupancy[i] !== 2'd0) begin
                n_fail++; $display("FAIL reset_occupancy dut%0d got %0d want 0", i, occupancy[i]);
            end
            if (out_data[i] !== 128'd0) begin
                n_fail++; $display("FAIL reset_out_data dut%0d got %0h want 0", i, out_data[i]);
            end
            if (in_ready[i] !== 1'b1) begin
                n_fail++; $display("FAIL reset_in_ready dut%0d got %0b want 1", i, in_ready[i]);
            end
        end
    endtask

    task automatic test_stream(input int i);
        logic exp_v;
        do_reset();
        out_ready[i] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            exp_v = (c >= 1 && c <= 8);
            n_checks += 3;
            if (out_valid[i] !== exp_v) begin
                n_fail++; $display("FAIL stream_valid dut%0d cyc%0d got %0b want %0b", i, c, out_valid[i], exp_v);
            end
            if (occupancy[i] !== {1'b0, exp_v}) begin
                n_fail++; $display("FAIL stream_occ dut%0d cyc%0d got %0d want %0d", i, c, occupancy[i], exp_v);
            end
            if (in_ready[i] !== 1'b1) begin
                n_fail++; $display("FAIL stream_in_ready dut%0d cyc%0d got %0b want 1", i, c, in_ready[i]);
            end
            if (exp_v) begin
                n_checks++;
                if (out_data[i] !== 128'(c)) begin
                    n_fail++; $display("FAIL stream_data dut%0d cyc%0d got %0h want %0h", i, c, out_data[i], c);
                end
            end
            in_valid[i] = (c < 8);
            in_data[i]  = 128'(c + 1);
        end
        in_valid[i] = 1'b0;
    endtask

    task automatic test_skid_backpressure();
        do_reset();
        @(negedge clk);
        in_valid[0] = 1'b1; in_data[0] = 128'hA;
        @(negedge clk);
        n_checks += 3;
        if (in_ready[0] !== 1'b1 || occupancy[0] !== 2'd1 || out_data[0] !== 128'hA) begin
            n_fail++; $display("FAIL skid_one rdy=%0b occ=%0d data=%0h want 1/1/a", in_ready[0], occupancy[0], out_data[0]);
        end
        in_data[0] = 128'hB;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks += 3;
            if (in_ready[0] !== 1'b0) begin
                n_fail++; $display("FAIL skid_full_ready k%0d got %0b want 0", k, in_ready[0]);
            end
            if (occupancy[0] !== 2'd2) begin
                n_fail++; $display("FAIL skid_full_occ k%0d got %0d want 2", k, occupancy[0]);
            end
            if (out_valid[0] !== 1'b1 || out_data[0] !== 128'hA) begin
                n_fail++; $display("FAIL skid_full_head k%0d valid=%0b data=%0h want 1/a", k, out_valid[0], out_data[0]);
            end
            in_data[0] = 128'hC;
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (out_data[0] !== 128'hB || occupancy[0] !== 2'd1) begin
            n_fail++; $display("FAIL skid_drain_b data=%0h occ=%0d want b/1", out_data[0], occupancy[0]);
        end
        if (in_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL skid_drain_ready got %0b want 1", in_ready[0]);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 128'hC || occupancy[0] !== 2'd1) begin
            n_fail++; $display("FAIL skid_drain_c valid=%0b data=%0h occ=%0d want 1/c/1", out_valid[0], out_data[0], occupancy[0]);
        end
        in_valid[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid[0] !== 1'b0 || occupancy[0] !== 2'd0) begin
            n_fail++; $display("FAIL skid_drain_empty valid=%0b occ=%0d want 0/0", out_valid[0], occupancy[0]);
        end
    endtask

    task automatic test_noskid_backpressure();
        do_reset();
        @(negedge clk);
        in_valid[1] = 1'b1; in_data[1] = 128'h5;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_data[1] = 128'h6;
            #1;
            n_checks += 2;
            if (in_ready[1] !== 1'b0) begin
                n_fail++; $display("FAIL reg_stall_ready k%0d got %0b want 0", k, in_ready[1]);
            end
            if (out_data[1] !== 128'h5 || occupancy[1] !== 2'd1) begin
                n_fail++; $display("FAIL reg_stall_hold k%0d data=%0h occ=%0d want 5/1", k, out_data[1], occupancy[1]);
            end
        end
        out_ready[1] = 1'b1;
        #1;
        n_checks++;
        if (in_ready[1] !== 1'b1) begin
            n_fail++; $display("FAIL reg_release_ready got %0b want 1", in_ready[1]);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== 128'h6 || occupancy[1] !== 2'd1) begin
            n_fail++; $display("FAIL reg_replace valid=%0b data=%0h occ=%0d want 1/6/1", out_valid[1], out_data[1], occupancy[1]);
        end
        in_valid[1] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid[1] !== 1'b0) begin
            n_fail++; $display("FAIL reg_empty valid=%0b want 0", out_valid[1]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        @(negedge clk);
        in_valid[0] = 1'b1; in_data[0] = 128'h11;
        @(negedge clk);
        in_data[0] = 128'h22;
        @(negedge clk);
        n_checks++;
        if (occupancy[0] !== 2'd2) begin
            n_fail++; $display("FAIL flush_pre_occ got %0d want 2", occupancy[0]);
        end
        in_data[0] = 128'h33; flush[0] = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        n_checks += 2;
        if (out_valid[0] !== 1'b0 || occupancy[0] !== 2'd0) begin
            n_fail++; $display("FAIL flush_full valid=%0b occ=%0d want 0/0", out_valid[0], occupancy[0]);
        end
        if (in_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL flush_full_ready got %0b want 1", in_ready[0]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid[0] !== 1'b0) begin
                n_fail++; $display("FAIL flush_leak k%0d valid=%0b data=%0h want 0", k, out_valid[0], out_data[0]);
            end
        end

        do_reset();
        @(negedge clk);
        in_valid[1] = 1'b1; in_data[1] = 128'h44;
        @(negedge clk);
        in_data[1] = 128'h55; out_ready[1] = 1'b1; flush[1] = 1'b1;
        #1;
        n_checks++;
        if (in_ready[1] !== 1'b1) begin
            n_fail++; $display("FAIL flush_ready_ungated got %0b want 1", in_ready[1]);
        end
        @(negedge clk);
        flush[1] = 1'b0; in_valid[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (out_valid[1] !== 1'b0 || occupancy[1] !== 2'd0) begin
                n_fail++; $display("FAIL flush_accept_drop k%0d valid=%0b occ=%0d want 0/0", k, out_valid[1], occupancy[1]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        in_valid[0] = 1'b1; in_data[0] = 128'h77;
        @(negedge clk);
        in_data[0] = 128'h88;
        @(negedge clk);
        in_valid[0] = 1'b0;
        n_checks++;
        if (occupancy[0] !== 2'd2) begin
            n_fail++; $display("FAIL arst_pre_occ got %0d want 2", occupancy[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks += 4;
        if (out_valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL arst_valid got %0b want 0", out_valid[0]);
        end
        if (occupancy[0] !== 2'd0) begin
            n_fail++; $display("FAIL arst_occ got %0d want 0", occupancy[0]);
        end
        if (out_data[0] !== 128'd0) begin
            n_fail++; $display("FAIL arst_data got %0h want 0", out_data[0]);
        end
        if (in_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL arst_ready got %0b want 1", in_ready[0]);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic exp_rdy, acc, iss;
        do_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_data[i][0] = '0;
            m_data[i][1] = '0;
        end
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                in_valid[i]  = ($urandom_range(0, 3) != 0);
                out_ready[i] = ($urandom_range(0, 3) != 0);
                flush[i]     = ($urandom_range(0, 63) == 0);
                in_data[i]   = {$urandom, $urandom, $urandom, $urandom};
                if (i >= 2) in_data[i] = in_data[i] & 128'd1;
            end
            #1;
            for (int i = 0; i < N; i++) begin
                // Capacity-2 FIFO for skid mode, capacity-1 pass-through register otherwise.
                exp_rdy = (i % 2 == 0) ? (m_cnt[i] < 2) : (m_cnt[i] == 0 || out_ready[i]);
                n_checks += 3;
                if (in_ready[i] !== exp_rdy) begin
                    n_fail++; $display("FAIL rand_ready dut%0d cyc%0d got %0b want %0b", i, c, in_ready[i], exp_rdy);
                end
                if (out_valid[i] !== (m_cnt[i] > 0)) begin
                    n_fail++; $display("FAIL rand_valid dut%0d cyc%0d got %0b want %0b", i, c, out_valid[i], m_cnt[i] > 0);
                end
                if (occupancy[i] !== 2'(m_cnt[i])) begin
                    n_fail++; $display("FAIL rand_occ dut%0d cyc%0d got %0d want %0d", i, c, occupancy[i], m_cnt[i]);
                end
                if (m_cnt[i] > 0) begin
                    n_checks++;
                    if (out_data[i] !== m_data[i][0]) begin
                        n_fail++; $display("FAIL rand_data dut%0d cyc%0d got %0h want %0h", i, c, out_data[i], m_data[i][0]);
                    end
                end
                acc = in_valid[i] & exp_rdy;
                iss = (m_cnt[i] > 0) & out_ready[i];
                if (flush[i]) begin
                    m_cnt[i] = 0;
                end else begin
                    if (iss) begin
                        m_data[i][0] = m_data[i][1];
                        m_cnt[i]--;
                    end
                    if (acc) begin
                        m_data[i][m_cnt[i]] = in_data[i];
                        m_cnt[i]++;
                    end
                end
            end
        end
        idle_all();
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_stream(0);
        test_stream(1);
        test_skid_backpressure();
        test_noskid_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
